// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side requests a division and the slave side reports results.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Divide by zero bypasses the iteration loop and flags the result.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ZDIV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             dz_q;
  logic             done_q;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             qbit;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             last;

  // One restoring step; trial's top bit is the borrow
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {2'b00, dsr_q};
    qbit    = ~trial[WIDTH+1];
    rem_d   = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
    dvd_d   = {dvd_q[WIDTH-2:0], qbit};
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.divisor != '0) ? CALC : ZDIV;
        end
      end
      CALC: begin
        if (last) state_d = DONE;
      end
      ZDIV:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q <= bus.dividend;
            dsr_q <= bus.divisor;
            rem_q <= '0;
            cnt_q <= '0;
          end
        end
        CALC: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            quo_q  <= dvd_d;
            rmd_q  <= rem_d[WIDTH-1:0];
            dz_q   <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ZDIV: begin
          quo_q  <= '1;
          rmd_q  <= dvd_q;
          dz_q   <= 1'b1;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dz_q;
endmodule
